// File: rtl/bm_pipelined_mac_pkg.sv
// Shared constants and types for the pipelined multiply(-accumulate) block.
// Optional feature macro: MULT_ACCUMULATE_EN (running-sum output, guard bits).
package bm_mult_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_STAGES    = 3;
  localparam int DEF_ACC_GUARD = 4;

  // Control half of a stage record. The data half is WIDTH-dependent, so each
  // stage carries it as a sized vector next to this struct.
  typedef struct packed {
    logic vld;
    logic clr;
  } stage_ctl_t;

  // Result width: full product, plus guard bits when accumulating.
  function automatic int out_w(input int width, input int guard);
`ifdef MULT_ACCUMULATE_EN
    return 2*width + guard;
`else
    return 2*width + 0*guard;
`endif
  endfunction

endpackage

// File: rtl/bm_pipelined_mac_if.sv
// Operand/result handshake bundle for bm_pipelined_mac.
// master = producer+consumer side, slave = the multiplier.
interface bm_pipelined_mac_if #(
  parameter int WIDTH = 8,
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             acc_clear;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;

  modport master (
    output in_valid, a_in, b_in, acc_clear, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, a_in, b_in, acc_clear, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/bm_pipelined_mac_stage.sv
// One holdable pipeline register: valid/clear/data, advances when i_en is set.
module bm_mult_stage
  import bm_mult_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_en,
  input  stage_ctl_t    i_ctl,
  input  logic [DW-1:0] i_data,
  output stage_ctl_t    o_ctl,
  output logic [DW-1:0] o_data
);

  stage_ctl_t    r_ctl;
  logic [DW-1:0] r_data;

  // Capture the upstream slot (valid or bubble) unless the pipe is stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ctl  <= '0;
      r_data <= '0;
    end else if (i_en) begin
      r_ctl  <= i_ctl;
      r_data <= i_data;
    end
  end

  assign o_ctl  = r_ctl;
  assign o_data = r_data;

endmodule

// File: rtl/bm_pipelined_mac.sv
// Pipelined unsigned multiplier with global-stall valid/ready flow control.
// Define MULT_ACCUMULATE_EN to output a wrapping running sum of products.
module bm_pipelined_mac
  import bm_mult_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int STAGES    = DEF_STAGES,
  parameter int ACC_GUARD = DEF_ACC_GUARD
) (
  input  logic               clock,
  input  logic               reset,
  bm_pipelined_mac_if.slave  bus
);

  localparam int DW    = 2*WIDTH;
  localparam int OUT_W = out_w(WIDTH, ACC_GUARD);

  // Index 0 is the incoming slot, index s is the output of stage s.
  stage_ctl_t [STAGES:0]         w_ctl;
  logic       [STAGES:0][DW-1:0] w_data;
  logic                          w_stall;
  logic                          w_accept;
  logic       [DW-1:0]           w_prod;

  // Whole pipe freezes while a result waits on the consumer; bubbles are
  // never squeezed out, so ready depends only on the output stage.
  assign w_stall      = w_ctl[STAGES].vld && !bus.out_ready;
  assign bus.in_ready = !w_stall;
  assign w_accept     = bus.in_valid && !w_stall;

  assign w_prod    = DW'(bus.a_in) * DW'(bus.b_in);
  assign w_ctl[0]  = '{vld: w_accept, clr: w_accept && bus.acc_clear};
  assign w_data[0] = w_accept ? w_prod : '0;

  for (genvar s = 1; s <= STAGES; s++) begin : g_stage
    bm_mult_stage #(.DW(DW)) u_stage (
      .clock  (clock),
      .reset  (reset),
      .i_en   (!w_stall),
      .i_ctl  (w_ctl[s-1]),
      .i_data (w_data[s-1]),
      .o_ctl  (w_ctl[s]),
      .o_data (w_data[s])
    );
  end

  assign bus.out_valid = w_ctl[STAGES].vld;

`ifdef MULT_ACCUMULATE_EN
  logic [OUT_W-1:0] r_acc;

  // Fold each valid product into the sum as it enters the final stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc <= '0;
    end else if (!w_stall && w_ctl[STAGES-1].vld) begin
      r_acc <= (w_ctl[STAGES-1].clr ? '0 : r_acc) + OUT_W'(w_data[STAGES-1]);
    end
  end

  assign bus.out_data = r_acc;
`else
  assign bus.out_data = w_data[STAGES];
`endif

endmodule

// File: tb/tb_bm_pipelined_mac.sv
// Directed bench for bm_pipelined_mac (WIDTH=8, STAGES=3, ACC_GUARD=4).
// Builds with or without MULT_ACCUMULATE_EN; mode-specific steps are guarded.
module tb_bm_pipelined_mac;
  import bm_mult_pkg::*;

  localparam int W  = 8;
  localparam int OW = out_w(8, 4);

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  bm_pipelined_mac_if #(.WIDTH(W), .OUT_W(OW)) bus ();

  bm_pipelined_mac #(.WIDTH(W), .STAGES(3), .ACC_GUARD(4)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
    bus.in_valid  = v;
    bus.a_in      = a;
    bus.b_in      = b;
    bus.acc_clear = c;
  endtask

  logic [31:0] got[$];
  int          idx;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    bus.out_ready = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    tick;

    // Reset state.
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);

    // Max operands: beat driven in cycle 0, result valid for exactly cycle 3.
    drive(1'b1, 8'd255, 8'd255, 1'b1);
    tick;
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    check("max_lat_c1", 32'(bus.out_valid), 32'd0);
    tick;
    check("max_lat_c2", 32'(bus.out_valid), 32'd0);
    tick;
    check("max_valid_c3", 32'(bus.out_valid), 32'd1);
    check("max_data",     32'(bus.out_data),  32'h0000FE01);
    tick;
    check("max_one_cycle", 32'(bus.out_valid), 32'd0);

    // Stream 1..5 x 2 with consumer stalled in cycles 3..6.
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      bus.out_ready = !(c >= 3 && c <= 6);
      drive(idx < 5, 8'(idx + 1), 8'd2, 1'b1);
      #1;
      if (c >= 3 && c <= 6) begin
        check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        check("stall_hold",     32'(bus.out_data), 32'd2);
      end
      if (bus.in_valid && bus.in_ready) idx++;
      if (bus.out_valid && bus.out_ready) got.push_back(32'(bus.out_data));
      tick;
    end
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    bus.out_ready = 1'b1;
    check("stream_count", 32'(got.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < got.size()) check("stream_data", got[k], 32'(2 * (k + 1)));
      else                check("stream_data", 32'hFFFF_FFFF, 32'(2 * (k + 1)));
    end

`ifdef MULT_ACCUMULATE_EN
    // Running sum: 100, 100+12, 112+25.
    drive(1'b1, 8'd10, 8'd10, 1'b1); tick;
    drive(1'b1, 8'd3,  8'd4,  1'b0); tick;
    drive(1'b1, 8'd5,  8'd5,  1'b0); tick;
    drive(1'b0, 8'd0,  8'd0,  1'b0);
    check("acc_v0", 32'(bus.out_valid), 32'd1);
    check("acc_0",  32'(bus.out_data),  32'd100);
    tick;
    check("acc_1",  32'(bus.out_data),  32'd112);
    tick;
    check("acc_2",  32'(bus.out_data),  32'd137);
    tick;

    // 17 x 65025 = 1105425 wraps to 56849 in 20 bits.
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, 8'd255, 8'd255, k == 0);
      tick;
    end
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    tick;
    tick;
    check("wrap_valid", 32'(bus.out_valid), 32'd1);
    check("wrap_data",  32'(bus.out_data),  32'd56849);
    tick;
    check("wrap_drain", 32'(bus.out_valid), 32'd0);
`else
    // acc_clear has no effect: plain products.
    drive(1'b1, 8'd3, 8'd4, 1'b1); tick;
    drive(1'b1, 8'd5, 8'd5, 1'b0); tick;
    drive(1'b0, 8'd0, 8'd0, 1'b1); tick;
    check("noacc_v0", 32'(bus.out_valid), 32'd1);
    check("noacc_0",  32'(bus.out_data),  32'd12);
    tick;
    check("noacc_1",  32'(bus.out_data),  32'd25);
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    tick;
`endif

    // Reset with two beats in flight; a beat offered during reset is dropped.
    drive(1'b1, 8'd1, 8'd1, 1'b1); tick;
    drive(1'b1, 8'd2, 8'd2, 1'b0);
    tick;
    drive(1'b1, 8'd9, 8'd9, 1'b1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    check("mid_rst_valid_c3", 32'(bus.out_valid), 32'd0);
    check("mid_rst_data",     32'(bus.out_data),  32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready),  32'd1);
    tick;
    check("mid_rst_valid_c4", 32'(bus.out_valid), 32'd0);
    tick;
    check("mid_rst_valid_c5", 32'(bus.out_valid), 32'd0);
    check("mid_rst_data_c5",  32'(bus.out_data),  32'd0);
    drive(1'b1, 8'd7, 8'd6, 1'b0);
    tick;
    drive(1'b0, 8'd0, 8'd0, 1'b0);
    check("post_rst_lat1", 32'(bus.out_valid), 32'd0);
    tick;
    check("post_rst_lat2", 32'(bus.out_valid), 32'd0);
    tick;
    check("post_rst_valid", 32'(bus.out_valid), 32'd1);
    check("post_rst_data",  32'(bus.out_data),  32'd42);
    tick;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bm_pipelined_mac.md
# bm_pipelined_mac

Parametrised, pipelined unsigned multiplier with valid/ready flow control and an optional running-sum accumulate mode. It is the next generation of the registered multiply benchmarks: operand width and pipeline depth are generic, and throughput is one product per cycle under backpressure. It sits as a leaf datapath block in synthesis regression benchmarks, fed by a producer and drained by a consumer that may stall.

## Interface
- WIDTH, 8, operand width in bits (≥2)
- STAGES, 3, pipeline depth = accept-to-output latency in cycles (≥1)
- ACC_GUARD, 4, extra accumulator bits above 2*WIDTH (used only with MULT_ACCUMULATE_EN)
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat present
- in_ready  out  1  block can accept a beat this cycle
- a_in  in  WIDTH  operand A
- b_in  in  WIDTH  operand B
- acc_clear  in  1  with accepted beat: restart running sum at this product (MULT_ACCUMULATE_EN only)
- out_valid  out  1  out_data holds a result
- out_ready  in  1  consumer takes result this cycle
- out_data  out  OUT_W  result; OUT_W = 2*WIDTH (+ACC_GUARD with MULT_ACCUMULATE_EN)

## Operation
- Accept when in_valid && in_ready at a rising edge; product a_in*b_in, full 2*WIDTH bits, unsigned, never truncated.
- Pipeline: STAGES registers, each carrying valid bit, data, clear flag. Product formed in stage 1; later stages pass through.
- Global stall: stall = out_valid && !out_ready; in_ready = !stall (combinational). On stall every stage holds; no beat lost, duplicated, or reordered.
- Bubbles are not collapsed: invalid slots advance like data.
- Result consumed when out_valid && out_ready; the next slot (valid or not) shifts into the output stage on that edge.
- Non-accumulate: out_data = product of the beat, zero-extended to OUT_W.
- Accumulate: at entry into final stage, acc <= (clear ? 0 : acc) + product, modulo 2^OUT_W (silent wrap); out_data = acc. Invalid slots do not change acc.
- Reset: all valid bits 0, all data regs and acc 0, out_valid=0, out_data=0; in_ready=1 in the cycle after reset deasserts. Reset mid-operation discards in-flight beats and running sum; no out_valid follows.
- in_valid during reset ignored.

## Timing
- Latency: beat accepted at edge k → out_valid/out_data valid after edge k+STAGES, absent stalls; each stall cycle adds one.
- Throughput: 1 beat/cycle while out_ready=1.
- in_ready depends combinationally on out_valid (reg) and out_ready only; no path from in_valid.
- Simultaneous accept and output consume in one cycle: both occur.
- out_data stable while out_valid && !out_ready.

## Configuration
- MULT_ACCUMULATE_EN defined: accumulator, ACC_GUARD bits, acc_clear behaviour as above.
- Not defined: OUT_W = 2*WIDTH, no accumulator register, acc_clear ignored (port present, unused), out_data = per-beat product.

## Structure
- Package bm_mult_pkg: default WIDTH/STAGES/ACC_GUARD constants, OUT_W width function, stage record typedef (valid, clear, data).
- Sub-module bm_mult_stage: one holdable pipeline register (valid/clear/data, enable = !stall, sync reset), instantiated STAGES times; top holds multiply, stall logic, accumulator.

## Test plan
- WIDTH=8, STAGES=3, out_ready=1: a=255,b=255 accepted at edge 0 → out_valid, out_data=0xFE01 after edge 3, exactly one cycle.
- Stream a=1..5, b=2 back-to-back, out_ready low 4 cycles mid-stream → in_ready low during stall; outputs 2,4,6,8,10 in order, none lost/duplicated.
- MULT_ACCUMULATE_EN: (10,10,clear=1),(3,4),(5,5) → out_data 100,112,137.
- MULT_ACCUMULATE_EN, OUT_W=20: 17 beats 255*255, first with clear → final out_data = 1105425 mod 2^20 = 56849.
- Two beats in flight, reset asserted one cycle → out_valid stays 0, out_data=0, next beat 7*6 → 42 after 3 cycles.
- Without macro: acc_clear toggled, (3,4),(5,5) → 12, 25; out_data width 16.
